multi_pulse_of_verifla: RTL and testbench

Parametrised, multi-channel edge-to-pulse converter for the VeriFLA capture and control path. Each channel turns a multi-cycle level change on its input into a registered pulse of programmable width. Per channel, the edge polarity is selected at run time, and a hold-off window rejects re-triggering. A shared counter totals the pulses issued, for trigger and user-button accounting.

---
 rtl/multi_pulse_of_verifla_if.sv | 23 ++
 rtl/multi_pulse_of_verifla.sv | 160 ++++++++++++++++
 tb/tb_multi_pulse_of_verifla.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/multi_pulse_of_verifla_if.sv
// Handshake/bus bundle for multi_pulse_of_verifla: control, per-channel levels and pulse outputs.
interface multi_pulse_of_verifla_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned COUNT_W  = 16
);
  logic                    en;
  logic                    cnt_clr;
  logic [2*CHANNELS-1:0]   edge_mode;
  logic [CHANNELS-1:0]     in;
  logic [CHANNELS-1:0]     pulse;
  logic [CHANNELS-1:0]     busy;
  logic [COUNT_W-1:0]      pulse_cnt;

  modport master (
    output en, cnt_clr, edge_mode, in,
    input  pulse, busy, pulse_cnt
  );

  modport slave (
    input  en, cnt_clr, edge_mode, in,
    output pulse, busy, pulse_cnt
  );
endinterface

// File: rtl/multi_pulse_of_verifla.sv
// Multi-channel edge-to-pulse converter with per-channel polarity, hold-off and a shared pulse counter.
// Define VERIFLA_PULSE_SYNC_EN to put a 2-flop synchroniser on every input bit.
module multi_pulse_of_verifla #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned PULSE_WIDTH = 1,
  parameter int unsigned HOLDOFF     = 1,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  multi_pulse_of_verifla_if.slave   bus
);

  localparam int unsigned MAX_T  = (PULSE_WIDTH > HOLDOFF) ? PULSE_WIDTH : HOLDOFF;
  localparam int unsigned CTR_W  = (MAX_T > 2) ? $clog2(MAX_T) : 1;
  localparam int unsigned NUM_W  = $clog2(CHANNELS + 1);
  localparam logic [CTR_W-1:0] PW_LOAD = CTR_W'(PULSE_WIDTH - 1);
  localparam logic [CTR_W-1:0] HO_LOAD = CTR_W'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t               state_q [CHANNELS];
  state_t               state_d [CHANNELS];
  logic [CTR_W-1:0]     ctr_q   [CHANNELS];
  logic [CTR_W-1:0]     ctr_d   [CHANNELS];
  logic [CHANNELS-1:0]  lvl_q, lvl_d;
  logic [CHANNELS-1:0]  pulse_q, pulse_d;
  logic [CHANNELS-1:0]  busy_q, busy_d;
  logic [CHANNELS-1:0]  start;
  logic [CHANNELS-1:0]  in_s;
  logic [NUM_W-1:0]     n_start;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;

`ifdef VERIFLA_PULSE_SYNC_EN
  logic [CHANNELS-1:0]  sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.in;
      sync2_q <= sync1_q;
    end
  end

  assign in_s = sync2_q;
`else
  assign in_s = bus.in;
`endif

  function automatic logic qualifies(input logic [1:0] mode, input logic level);
    case (mode)
      2'b00:   return level;
      2'b01:   return !level;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Per-channel next state plus popcount of channels entering PULSE
  always_comb begin
    lvl_d   = lvl_q;
    pulse_d = pulse_q;
    busy_d  = busy_q;
    start   = '0;
    n_start = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      ctr_d[c]   = ctr_q[c];
    end

    for (int c = 0; c < CHANNELS; c++) begin
      if (!bus.en || (bus.edge_mode[2*c +: 2] == 2'b11)) begin
        // Disabled channels track the level so re-enabling never fires on a static input
        state_d[c] = IDLE;
        pulse_d[c] = 1'b0;
        ctr_d[c]   = '0;
        lvl_d[c]   = in_s[c];
      end else begin
        case (state_q[c])
          IDLE: begin
            if (in_s[c] != lvl_q[c]) begin
              lvl_d[c] = in_s[c];
              if (qualifies(bus.edge_mode[2*c +: 2], in_s[c])) begin
                state_d[c] = PULSE;
                pulse_d[c] = 1'b1;
                ctr_d[c]   = PW_LOAD;
                start[c]   = 1'b1;
              end else if (HOLDOFF > 0) begin
                state_d[c] = HOLD;
                ctr_d[c]   = HO_LOAD;
              end
            end
          end
          PULSE: begin
            if (ctr_q[c] != '0) begin
              ctr_d[c] = ctr_q[c] - CTR_W'(1);
            end else begin
              pulse_d[c] = 1'b0;
              if (HOLDOFF > 0) begin
                state_d[c] = HOLD;
                ctr_d[c]   = HO_LOAD;
              end else begin
                state_d[c] = IDLE;
              end
            end
          end
          HOLD: begin
            if (ctr_q[c] != '0) begin
              ctr_d[c] = ctr_q[c] - CTR_W'(1);
            end else begin
              state_d[c] = IDLE;
            end
          end
          default: begin
            state_d[c] = IDLE;
            pulse_d[c] = 1'b0;
            ctr_d[c]   = '0;
          end
        endcase
      end
      busy_d[c] = (state_d[c] != IDLE);
      n_start   = n_start + NUM_W'(start[c]);
    end

    cnt_d = bus.cnt_clr ? '0 : (cnt_q + COUNT_W'(n_start));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= IDLE;
        ctr_q[c]   <= '0;
      end
      lvl_q   <= '0;
      pulse_q <= '0;
      busy_q  <= '0;
      cnt_q   <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        ctr_q[c]   <= ctr_d[c];
      end
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pulse     = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.pulse_cnt = cnt_q;

endmodule

// File: tb/tb_multi_pulse_of_verifla.sv
// Bench for multi_pulse_of_verifla: vector table on a default instance, hand sequences on a PW=3/HO=2/COUNT_W=2 instance.
module tb_multi_pulse_of_verifla;

  logic clk;
  logic reset;

  multi_pulse_of_verifla_if #(.CHANNELS(4), .COUNT_W(16)) bus_a ();
  multi_pulse_of_verifla_if #(.CHANNELS(4), .COUNT_W(2))  bus_b ();

  multi_pulse_of_verifla #(
    .CHANNELS(4), .PULSE_WIDTH(1), .HOLDOFF(1), .COUNT_W(16)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  multi_pulse_of_verifla #(
    .CHANNELS(4), .PULSE_WIDTH(3), .HOLDOFF(2), .COUNT_W(2)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        clr;
    logic [7:0]  mode;
    logic [3:0]  in;
    logic [3:0]  ep;
    logic [3:0]  eb;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[$];
  int   n_pass;
  int   n_total;

  logic [11:0] b_pulse_seq = 12'b000111000111;
  logic [11:0] b_busy_seq  = 12'b011111011111;
  logic [1:0]  b_cnt_seq [3] = '{2'd3, 2'd0, 2'd1};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic en, input logic clr, input logic [7:0] mode, input logic [3:0] in,
                     input logic [3:0] ep, input logic [3:0] eb, input logic [15:0] ec);
    vec_t v;
    v.en = en; v.clr = clr; v.mode = mode; v.in = in; v.ep = ep; v.eb = eb; v.ec = ec;
    vecs.push_back(v);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b0;
    bus_a.en = 1'b1; bus_a.cnt_clr = 1'b0; bus_a.edge_mode = 8'h00; bus_a.in = 4'h0;
    bus_b.en = 1'b1; bus_b.cnt_clr = 1'b0; bus_b.edge_mode = 8'h08; bus_b.in = 4'h0;

    //   en clr mode   in    pulse busy  cnt
    add(1, 0, 8'h00, 4'h0, 4'h0, 4'h0, 16'd0);
    add(1, 0, 8'h00, 4'h1, 4'h1, 4'h1, 16'd1);
    add(1, 0, 8'h00, 4'h1, 4'h0, 4'h1, 16'd1);
    add(1, 0, 8'h00, 4'h1, 4'h0, 4'h0, 16'd1);
    add(1, 0, 8'h00, 4'h1, 4'h0, 4'h0, 16'd1);
    add(1, 0, 8'h00, 4'h0, 4'h0, 4'h1, 16'd1);
    add(1, 0, 8'h00, 4'h0, 4'h0, 4'h0, 16'd1);
    add(1, 0, 8'h00, 4'h0, 4'h0, 4'h0, 16'd1);
    add(1, 1, 8'h00, 4'hF, 4'hF, 4'hF, 16'd0);
    add(1, 0, 8'h00, 4'hF, 4'h0, 4'hF, 16'd0);
    add(1, 0, 8'h00, 4'hF, 4'h0, 4'h0, 16'd0);
    add(1, 0, 8'h00, 4'h0, 4'h0, 4'hF, 16'd0);
    add(1, 0, 8'h00, 4'h0, 4'h0, 4'h0, 16'd0);
    add(1, 0, 8'h00, 4'hF, 4'hF, 4'hF, 16'd4);
    add(1, 0, 8'h00, 4'hF, 4'h0, 4'hF, 16'd4);
    add(1, 0, 8'h00, 4'hF, 4'h0, 4'h0, 16'd4);
    add(0, 0, 8'h00, 4'h0, 4'h0, 4'h0, 16'd4);
    add(0, 0, 8'h00, 4'h3, 4'h0, 4'h0, 16'd4);
    add(1, 0, 8'h00, 4'h3, 4'h0, 4'h0, 16'd4);
    add(1, 0, 8'h00, 4'h7, 4'h4, 4'h4, 16'd5);
    add(0, 0, 8'h00, 4'h7, 4'h0, 4'h0, 16'd5);
    add(1, 0, 8'h00, 4'h0, 4'h0, 4'h7, 16'd5);
    add(1, 0, 8'h00, 4'h0, 4'h0, 4'h0, 16'd5);
    add(1, 0, 8'hD8, 4'hF, 4'h3, 4'h7, 16'd7);
    add(1, 0, 8'hD8, 4'hF, 4'h0, 4'h3, 16'd7);
    add(1, 0, 8'hD8, 4'hF, 4'h0, 4'h0, 16'd7);
    add(1, 0, 8'hD8, 4'h0, 4'h6, 4'h7, 16'd9);
    add(1, 0, 8'hD8, 4'h0, 4'h0, 4'h6, 16'd9);
    add(1, 0, 8'hD8, 4'h0, 4'h0, 4'h0, 16'd9);
    add(1, 0, 8'hD8, 4'h4, 4'h0, 4'h4, 16'd9);
    add(1, 0, 8'hD8, 4'h0, 4'h0, 4'h0, 16'd9);
    add(1, 0, 8'hD8, 4'h0, 4'h4, 4'h4, 16'd10);
    add(1, 0, 8'hD8, 4'h4, 4'h0, 4'h4, 16'd10);
    add(1, 0, 8'hD8, 4'h0, 4'h0, 4'h0, 16'd10);
    add(1, 0, 8'hD8, 4'h0, 4'h0, 4'h0, 16'd10);
    add(1, 1, 8'hD8, 4'h0, 4'h0, 4'h0, 16'd0);

    // Reset state
    step();
    step();
    check("rst a pulse", 32'(bus_a.pulse), 32'h0);
    check("rst a busy",  32'(bus_a.busy),  32'h0);
    check("rst a cnt",   32'(bus_a.pulse_cnt), 32'h0);
    check("rst b pulse", 32'(bus_b.pulse), 32'h0);
    check("rst b busy",  32'(bus_b.busy),  32'h0);
    check("rst b cnt",   32'(bus_b.pulse_cnt), 32'h0);
    #3 reset = 1'b1;

    foreach (vecs[i]) begin
      bus_a.en        = vecs[i].en;
      bus_a.cnt_clr   = vecs[i].clr;
      bus_a.edge_mode = vecs[i].mode;
      bus_a.in        = vecs[i].in;
      step();
      check($sformatf("v%0d pulse", i), 32'(bus_a.pulse),     32'(vecs[i].ep));
      check($sformatf("v%0d busy", i),  32'(bus_a.busy),      32'(vecs[i].eb));
      check($sformatf("v%0d cnt", i),   32'(bus_a.pulse_cnt), 32'(vecs[i].ec));
    end
    bus_a.cnt_clr = 1'b0;

    // Both-edge channel, release two cycles after the press: second pulse at rise+6
    bus_b.in[1] = 1'b1;
    for (int j = 0; j < 12; j++) begin
      if (j == 2) bus_b.in[1] = 1'b0;
      step();
      check($sformatf("b1 c%0d pulse", j), 32'(bus_b.pulse), 32'({2'b00, b_pulse_seq[j], 1'b0}));
      check($sformatf("b1 c%0d busy", j),  32'(bus_b.busy),  32'({2'b00, b_busy_seq[j], 1'b0}));
      if (j == 0) check("b1 cnt first",  32'(bus_b.pulse_cnt), 32'd1);
      if (j == 6) check("b1 cnt second", 32'(bus_b.pulse_cnt), 32'd2);
    end

    // Two-bit counter wraps: 3, 0, 1
    for (int p = 0; p < 3; p++) begin
      bus_b.in[1] = ~bus_b.in[1];
      step();
      check($sformatf("wrap%0d pulse", p), 32'(bus_b.pulse), 32'h2);
      check($sformatf("wrap%0d cnt", p),   32'(bus_b.pulse_cnt), 32'(b_cnt_seq[p]));
      repeat (5) step();
      check($sformatf("wrap%0d idle", p),  32'(bus_b.busy), 32'h0);
    end

    // Asynchronous reset in the middle of a pulse
    bus_b.in[1]     = ~bus_b.in[1];
    bus_a.edge_mode = 8'h00;
    bus_a.in        = 4'h1;
    step();
    check("pre-rst a pulse", 32'(bus_a.pulse), 32'h1);
    check("pre-rst b pulse", 32'(bus_b.pulse), 32'h2);
    #3 reset = 1'b0;
    #1;
    check("async a pulse", 32'(bus_a.pulse), 32'h0);
    check("async a busy",  32'(bus_a.busy),  32'h0);
    check("async a cnt",   32'(bus_a.pulse_cnt), 32'h0);
    check("async b pulse", 32'(bus_b.pulse), 32'h0);
    check("async b busy",  32'(bus_b.busy),  32'h0);
    check("async b cnt",   32'(bus_b.pulse_cnt), 32'h0);

    // Falling-edge channel held high through reset: no pulse until the fall
    bus_a.edge_mode = 8'hD8;
    bus_a.in        = 4'h4;
    bus_b.in        = 4'h0;
    step();
    step();
    #3 reset = 1'b1;
    step();
    check("hi-rst pulse", 32'(bus_a.pulse), 32'h0);
    check("hi-rst busy",  32'(bus_a.busy),  32'h4);
    step();
    check("hi-rst idle",  32'(bus_a.busy),  32'h0);
    bus_a.in = 4'h0;
    step();
    check("fall pulse", 32'(bus_a.pulse), 32'h4);
    check("fall cnt",   32'(bus_a.pulse_cnt), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
